// File: rtl/countdown_timer.sv
// Loadable MM:SS BCD countdown timer with one-second prescaler, start/stop/load
// control FSM and a one-cycle expiry pulse when the count reaches 00:00.
module countdown_timer #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int PRE_WIDTH = 27
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] count,
    output logic        running,
    output logic        paused,
    output logic        done,
    output logic        expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(TICK_DIV - 1);

    state_t               state_reg, state_next;
    logic [15:0]          count_reg, count_next;
    logic [PRE_WIDTH-1:0] pre_reg, pre_next;
    logic                 running_reg, paused_reg, done_reg, expired_reg;
    logic                 expired_next;
    logic [15:0]          load_clamped;
    logic [15:0]          count_dec;

    // Ones digits (even positions) clamp to 9, tens digits (odd positions) to 5.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_clamp
            localparam logic [3:0] LIMIT = (gi % 2 == 0) ? 4'd9 : 4'd5;
            assign load_clamped[gi*4 +: 4] =
                (load_value[gi*4 +: 4] > LIMIT) ? LIMIT : load_value[gi*4 +: 4];
        end
    endgenerate

    // One-second BCD borrow chain; only applied while count is non-zero.
    always_comb begin
        count_dec = count_reg;
        if (count_reg[3:0] != 4'd0) begin
            count_dec[3:0] = count_reg[3:0] - 4'd1;
        end else begin
            count_dec[3:0] = 4'd9;
            if (count_reg[7:4] != 4'd0) begin
                count_dec[7:4] = count_reg[7:4] - 4'd1;
            end else begin
                count_dec[7:4] = 4'd5;
                if (count_reg[11:8] != 4'd0) begin
                    count_dec[11:8] = count_reg[11:8] - 4'd1;
                end else begin
                    count_dec[11:8]  = 4'd9;
                    count_dec[15:12] = count_reg[15:12] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        pre_next     = pre_reg;
        expired_next = 1'b0;
        if (load) begin
            count_next = load_clamped;
            pre_next   = '0;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!stop && start && count_reg != 16'h0000) begin
                        state_next = RUN;
                        pre_next   = '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_next = PAUSE;
                    end else if (pre_reg == PRE_LAST) begin
                        pre_next   = '0;
                        count_next = count_dec;
                        if (count_dec == 16'h0000) begin
                            state_next   = DONE;
                            expired_next = 1'b1;
                        end
                    end else begin
                        pre_next = pre_reg + PRE_WIDTH'(1);
                    end
                end
                PAUSE: begin
                    // Prescaler keeps its accumulated value across the pause.
                    if (!stop && start) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            count_reg   <= 16'h0000;
            pre_reg     <= '0;
            running_reg <= 1'b0;
            paused_reg  <= 1'b0;
            done_reg    <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            pre_reg     <= pre_next;
            running_reg <= (state_next == RUN);
            paused_reg  <= (state_next == PAUSE);
            done_reg    <= (state_next == DONE);
            expired_reg <= expired_next;
        end
    end

    assign count   = count_reg;
    assign running = running_reg;
    assign paused  = paused_reg;
    assign done    = done_reg;
    assign expired = expired_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4; hand-computed expectations
// checked by immediate assertions after each clock edge.
module tb_countdown_timer;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        stop;
    logic [15:0] count;
    logic        running;
    logic        paused;
    logic        done;
    logic        expired;

    int n_asserts = 0;
    int n_fail    = 0;

    countdown_timer #(
        .TICK_DIV  (4),
        .PRE_WIDTH (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .running    (running),
        .paused     (paused),
        .done       (done),
        .expired    (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic r, input logic p, input logic d, input logic e);
        check(tag, {12'h0, running, paused, done, expired}, {12'h0, r, p, d, e});
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1'b1;
        load_value = v;
        tick(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        load       = 1'b0;
        load_value = 16'h0000;
        start      = 1'b0;
        stop       = 1'b0;
        tick(2);
        check("reset_count", count, 16'h0000);
        flags("reset_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick(1);

        // Load clamping and start with zero count
        do_load(16'h7A9F);
        check("clamp_count", count, 16'h5959);
        flags("clamp_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        do_load(16'h0000);
        do_start();
        flags("start_zero_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(5);
        check("start_zero_count", count, 16'h0000);

        // Borrow chain 10:00 -> 09:59 -> 09:58
        do_load(16'h1000);
        do_start();
        flags("borrow_run", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        check("borrow_before_tick", count, 16'h1000);
        tick(1);
        check("borrow_first", count, 16'h0959);
        flags("borrow_run_mid", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        check("borrow_second", count, 16'h0958);

        // Load during RUN returns to IDLE
        do_load(16'h0002);
        check("load_in_run_count", count, 16'h0002);
        flags("load_in_run_flags", 1'b0, 1'b0, 1'b0, 1'b0);

        // Expiry
        do_start();
        tick(4);
        check("expiry_0001", count, 16'h0001);
        tick(3);
        check("expiry_pre_zero", count, 16'h0001);
        flags("expiry_pre_flags", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        check("expiry_zero", count, 16'h0000);
        flags("expiry_pulse", 1'b0, 1'b0, 1'b1, 1'b1);
        tick(1);
        flags("expiry_after", 1'b0, 1'b0, 1'b1, 1'b0);
        do_start();
        do_stop();
        do_start();
        check("done_hold_count", count, 16'h0000);
        flags("done_hold_flags", 1'b0, 1'b0, 1'b1, 1'b0);

        // Pause and resume with accumulated prescaler
        do_load(16'h0005);
        do_start();
        tick(2);
        do_stop();
        flags("pause_flags", 1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_count", count, 16'h0005);
        tick(20);
        check("pause_hold_count", count, 16'h0005);
        flags("pause_hold_flags", 1'b0, 1'b1, 1'b0, 1'b0);
        do_start();
        flags("resume_flags", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        check("resume_plus1", count, 16'h0005);
        tick(1);
        check("resume_plus2", count, 16'h0004);

        // start+stop together in IDLE
        do_load(16'h0030);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        flags("idle_start_stop", 1'b0, 1'b0, 1'b0, 1'b0);

        // load+stop together in RUN
        do_start();
        tick(1);
        load       = 1'b1;
        stop       = 1'b1;
        load_value = 16'h0123;
        tick(1);
        load = 1'b0;
        stop = 1'b0;
        check("load_stop_count", count, 16'h0123);
        flags("load_stop_flags", 1'b0, 1'b0, 1'b0, 1'b0);

        // stop on the tick cycle defers the decrement
        do_start();
        tick(3);
        do_stop();
        check("stop_tick_count", count, 16'h0123);
        flags("stop_tick_flags", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(5);
        check("stop_tick_hold", count, 16'h0123);
        do_start();
        check("stop_tick_resume", count, 16'h0123);
        tick(1);
        check("stop_tick_dec", count, 16'h0122);

        // Asynchronous reset between edges
        do_load(16'h0500);
        do_start();
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_count", count, 16'h0000);
        flags("async_flags", 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        tick(1);
        check("post_reset_idle", count, 16'h0000);
        do_load(16'h0002);
        do_start();
        tick(4);
        check("post_reset_dec", count, 16'h0001);
        flags("post_reset_flags", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable MM:SS countdown timer, the down-counting companion to the stopwatch's up-counting digit chain. It holds a 4-digit BCD value and decrements it once per second from a built-in prescaler. A start/stop/load control FSM governs it, and it flags expiry when the value reaches 00:00. It sits between the debounced/one-shot button logic and the seven-segment display driver.

## Interface
- TICK_DIV, 100_000_000: clk cycles per one-second decrement; must be ≥ 2.
- PRE_WIDTH, 27: prescaler width; must satisfy 2^PRE_WIDTH ≥ TICK_DIV.
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle pulse; loads load_value.
- load_value  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
- start  input  1  single-cycle pulse; begin or resume counting.
- stop  input  1  single-cycle pulse; pause counting.
- count  output  16  current BCD value, same digit order as load_value.
- running  output  1  high while in RUN.
- paused  output  1  high while in PAUSE.
- done  output  1  high while in DONE.
- expired  output  1  one-cycle pulse on reaching 00:00 by decrement.

## Operation
- FSM states are IDLE, RUN, PAUSE and DONE; all outputs are registered.
- **Reset** (reset_n low, asynchronous):
  - state=IDLE, count=16'h0000, prescaler=0.
  - running=paused=done=expired=0.
- **Control priority per cycle:** load > stop > start.
- **load**, in any state:
  - count ← sanitized load_value; prescaler ← 0; state ← IDLE.
  - Sanitizing clamps each ones digit >9 to 9 and each tens digit >5 to 5. Example: 16'h7A9F loads as 16'h5959.
- **IDLE:**
  - start with count≠0 → RUN, prescaler ← 0.
  - start with count=0 is ignored.
- **RUN:**
  - stop → PAUSE; the prescaler holds and no decrement occurs that cycle.
  - Otherwise the prescaler increments each cycle.
  - On a cycle where prescaler = TICK_DIV−1, the prescaler wraps to 0 and count decrements by one second.
  - start is ignored.
- **PAUSE:**
  - start → RUN; the prescaler resumes from its held value.
  - stop is ignored.
- **DONE:** held until load or reset; start and stop are ignored.
- **BCD decrement (borrow chain):**
  - sec_ones: 0→9, with borrow into sec_tens.
  - sec_tens: 0→5, with borrow into min_ones.
  - min_ones: 0→9, with borrow into min_tens.
  - min_tens decrements and never underflows, because decrement only occurs with count≠0.
- **Expiry:** a decrement producing 16'h0000 sets state ← DONE and expired ← 1 for exactly one cycle. count stays 0000.
- **Range:** maximum value is 59:59. Non-BCD values never appear on count.

## Timing
- Control pulses sampled at edge N take effect on outputs at N+1.
- start at edge N:
  - running=1 from N+1.
  - The first decrement is visible on count at edge N+TICK_DIV.
  - Each subsequent decrement follows TICK_DIV cycles later.
- After a pause, the interval to the next decrement is TICK_DIV minus the prescaler cycles already accumulated.
- expired and done rise in the same cycle that count becomes 0000. expired falls one cycle later; done persists.
- load coincident with the final tick: load wins; no expired pulse; state IDLE.
- stop coincident with a tick: stop wins; the tick is deferred, since the prescaler holds at TICK_DIV−1 and the decrement occurs on the first RUN cycle after resume.
- reset_n asserted mid-RUN: outputs clear immediately, without waiting for clk.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset and load clamping:** reset, then load 16'h7A9F → count=16'h5959 and all flags 0. start with count=0000 → state stays IDLE, running=0.
- **Borrow chain:** load 16'h1000, start → after 4 cycles count=16'h0959; after 4 more, count=16'h0958. running=1 throughout.
- **Expiry:** load 16'h0002, start → count 0001, then 0000 at 8 cycles after start. expired high exactly 1 cycle, done stays 1, and further start pulses change nothing.
- **Pause/resume:** load 16'h0005, start, stop after 2 RUN cycles → paused=1, count holds 0005 for 20 cycles. start → decrement to 0004 exactly 2 cycles after resume.
- **Collisions:**
  - start+stop in the same cycle in IDLE → stays IDLE.
  - load+stop in RUN → IDLE with the loaded value.
  - stop on the tick cycle → no decrement until resume.
- **Asynchronous reset:** pulse reset_n low between clk edges mid-RUN → count=0000 and running=0 before the next edge; normal operation after release.
